// File: rtl/async_rx_endpoint_if.sv
// async_rx_endpoint_if: dequeue port plus the gray-coded crossing bundle between the two endpoints
interface async_rx_endpoint_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int ADDR = $clog2(DEPTH);
    logic                   deq_ready;
    logic                   deq_valid;
    logic [WIDTH-1:0]       deq_bits;
    logic [WIDTH*DEPTH-1:0] mem;
    logic [ADDR:0]          widx;
    logic [ADDR:0]          ridx;
    logic                   widx_valid;
    logic                   source_reset_n;
    logic                   ridx_valid;
    logic                   sink_reset_n;
    modport master (
        input  deq_valid, deq_bits, ridx, ridx_valid, sink_reset_n,
        output deq_ready, mem, widx, widx_valid, source_reset_n
    );
    modport slave (
        input  deq_ready, mem, widx, widx_valid, source_reset_n,
        output deq_valid, deq_bits, ridx, ridx_valid, sink_reset_n
    );
endinterface

// File: rtl/async_rx_endpoint.sv
// async_rx_endpoint: dequeue-side endpoint of the gray-coded asynchronous crossing
module async_rx_endpoint #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int SYNC  = 3
) (
    input logic clock,
    input logic reset,
    async_rx_endpoint_if.slave io
);
    localparam int ADDR = $clog2(DEPTH);
    logic [SYNC-1:0][ADDR:0] widx_sync;
    logic [SYNC-1:0]         src_sync;
    logic [SYNC-1:0]         wv_sync;
    logic [ADDR:0]           rbin, rbin_next, rgray, widx_s;
    logic                    src_ok_s, tx_ready, avail, load;
    logic [WIDTH-1:0]        slots [DEPTH];
    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_slot
            assign slots[k] = io.mem[k*WIDTH +: WIDTH];
        end
    endgenerate
    assign widx_s    = widx_sync[SYNC-1];
    assign src_ok_s  = src_sync[SYNC-1];
    assign tx_ready  = src_ok_s & wv_sync[SYNC-1];
    assign avail     = tx_ready & (rgray != widx_s);
    assign load      = avail & (~io.deq_valid | io.deq_ready);
    assign rbin_next = load ? rbin + 1'b1 : rbin;
    assign io.ridx   = rgray;
    // bring the transmitter's index and status flags into the dequeue clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            widx_sync <= '0;
            src_sync  <= '0;
            wv_sync   <= '0;
        end else begin
            widx_sync <= {widx_sync[SYNC-2:0], io.widx};
            src_sync  <= {src_sync[SYNC-2:0], io.source_reset_n};
            wv_sync   <= {wv_sync[SYNC-2:0], io.widx_valid};
        end
    end
    // read pointer and output register; a transmitter reset drops everything back to index 0
    always_ff @(posedge clock) begin
        if (reset) begin
            rbin            <= '0;
            rgray           <= '0;
            io.deq_valid    <= 1'b0;
            io.deq_bits     <= '0;
            io.ridx_valid   <= 1'b0;
            io.sink_reset_n <= 1'b0;
        end else begin
            io.sink_reset_n <= 1'b1;
            io.ridx_valid   <= src_ok_s;
            if (!src_ok_s) begin
                rbin         <= '0;
                rgray        <= '0;
                io.deq_valid <= 1'b0;
            end else begin
                rbin  <= rbin_next;
                rgray <= rbin_next ^ (rbin_next >> 1);
                if (load) begin
                    io.deq_valid <= 1'b1;
                    io.deq_bits  <= slots[rbin[ADDR-1:0]];
                end else if (io.deq_ready) begin
                    io.deq_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_async_rx_endpoint.sv
// tb_async_rx_endpoint: vector table for corner sequences plus a queue-based scoreboard for random traffic
module tb_async_rx_endpoint;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    async_rx_endpoint_if #(.WIDTH(4), .DEPTH(8)) io ();
    async_rx_endpoint #(.WIDTH(4), .DEPTH(8), .SYNC(3)) dut (.clock(clock), .reset(reset), .io(io));

    typedef struct {
        logic       rst, rdy, src, wv;
        logic [3:0] widx;
        logic       v, cb;
        logic [3:0] bits, ridx;
        logic       rv, snk;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   wbin = 0;
    int   fires = 0;
    int   q[$];
    bit   seen8, seen_wrap;

    function automatic logic [3:0] gray(input int x);
        logic [3:0] b;
        b = 4'(x);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input int cnt, input logic rst, rdy, src, wv, input logic [3:0] w,
                       input logic v, cb, input logic [3:0] b, r, input logic rv, snk);
        vec_t t;
        t = '{rst, rdy, src, wv, w, v, cb, b, r, rv, snk};
        for (int i = 0; i < cnt; i++) tbl.push_back(t);
    endtask

    task automatic wr();
        logic [3:0] v;
        v = 4'($urandom);
        io.mem[(wbin % 8) * 4 +: 4] = v;
        q.push_back(int'(v));
        wbin++;
        io.widx = gray(wbin);
    endtask

    // mode 1: ready always high; mode 2: random ready; mode 3: random ready and random writes
    task automatic run(input string nm, input int nwr, input int mode, input bit gapchk);
        int  written = 0;
        int  cyc = 0;
        int  gaps = 0;
        int  f0 = fires;
        bit  started = 0;
        logic rdy;
        while ((written < nwr || q.size() > 0) && cyc < 2000) begin
            if (io.deq_valid) begin
                if (q.size() == 0) chk({nm, "_spurious_valid"}, 1, 0);
                else chk({nm, "_bits"}, 32'(io.deq_bits), 32'(q[0]));
            end else if (gapchk && started && q.size() > 0) gaps++;
            if (io.ridx == 4'b1000) seen8 = 1;
            if (seen8 && io.ridx == 4'b0000) seen_wrap = 1;
            rdy = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            io.deq_ready = rdy;
            if (io.deq_valid && rdy && q.size() > 0) begin
                void'(q.pop_front());
                fires++;
                started = 1;
            end
            if (written < nwr && (wbin - fires) < 8 && (mode != 3 || $urandom_range(0, 1) == 1)) begin
                wr();
                written++;
            end
            tick();
            cyc++;
        end
        chk({nm, "_timeout"}, 32'(cyc >= 2000), 0);
        chk({nm, "_fires"}, fires - f0, nwr);
        if (gapchk) chk({nm, "_gaps"}, gaps, 0);
        chk({nm, "_empty_valid"}, 32'(io.deq_valid), 0);
        chk({nm, "_empty_ridx"}, 32'(io.ridx), 32'(gray(wbin)));
        io.deq_ready = 1'b1;
        repeat (3) tick();
        chk({nm, "_ridx_hold"}, 32'(io.ridx), 32'(gray(wbin)));
        chk({nm, "_valid_hold"}, 32'(io.deq_valid), 0);
    endtask

    initial begin
        io.deq_ready = 0;
        io.source_reset_n = 0;
        io.widx_valid = 0;
        io.widx = '0;
        io.mem = '0;
        io.mem[3:0] = 4'hA;
        io.mem[7:4] = 4'h3;
        io.mem[11:8] = 4'hC;
        add(1, 1,0,0,0,4'd0, 0,1,4'h0,4'd0,0,0);
        add(3, 0,0,1,1,4'd0, 0,0,4'h0,4'd0,0,1);
        add(1, 0,0,1,1,4'd0, 0,0,4'h0,4'd0,1,1);
        add(3, 0,0,1,1,4'd1, 0,0,4'h0,4'd0,1,1);
        add(2, 0,0,1,1,4'd1, 1,1,4'hA,4'd1,1,1);
        add(1, 0,1,1,1,4'd1, 0,0,4'h0,4'd1,1,1);
        add(3, 0,0,1,1,4'd2, 0,0,4'h0,4'd1,1,1);
        add(2, 0,0,1,1,4'd2, 1,1,4'h3,4'd3,1,1);
        add(3, 0,0,0,1,4'd2, 1,1,4'h3,4'd3,1,1);
        add(1, 0,0,0,1,4'd2, 0,0,4'h0,4'd0,0,1);
        add(3, 0,0,1,1,4'd1, 0,0,4'h0,4'd0,0,1);
        add(1, 0,0,1,1,4'd1, 1,1,4'hA,4'd1,1,1);
        add(1, 0,1,1,1,4'd1, 0,0,4'h0,4'd1,1,1);
        add(3, 0,1,1,1,4'd2, 0,0,4'h0,4'd1,1,1);
        add(1, 0,1,1,1,4'd2, 1,1,4'h3,4'd3,1,1);
        add(1, 0,1,1,1,4'd2, 1,1,4'hC,4'd2,1,1);
        add(1, 1,1,1,1,4'd2, 0,1,4'h0,4'd0,0,0);
        add(1, 0,1,1,1,4'd2, 0,0,4'h0,4'd0,0,1);
        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            io.deq_ready = tbl[i].rdy;
            io.source_reset_n = tbl[i].src;
            io.widx_valid = tbl[i].wv;
            io.widx = tbl[i].widx;
            tick();
            chk($sformatf("row%0d_valid", i), 32'(io.deq_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d_ridx", i), 32'(io.ridx), 32'(tbl[i].ridx));
            chk($sformatf("row%0d_ridx_valid", i), 32'(io.ridx_valid), 32'(tbl[i].rv));
            chk($sformatf("row%0d_sink_reset_n", i), 32'(io.sink_reset_n), 32'(tbl[i].snk));
            if (tbl[i].cb) chk($sformatf("row%0d_bits", i), 32'(io.deq_bits), 32'(tbl[i].bits));
        end
        reset = 1;
        io.widx = '0;
        io.deq_ready = 0;
        tick();
        reset = 0;
        repeat (5) tick();
        seen8 = 0;
        seen_wrap = 0;
        run("burst", 20, 1, 1);
        chk("burst_ridx_1000_seen", 32'(seen8), 1);
        chk("burst_ridx_wrap_seen", 32'(seen_wrap), 1);
        run("backpressure", 8, 2, 0);
        run("random", 60, 3, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/async_rx_endpoint.md
Name: async_rx_endpoint

Overview:
- Receiving (dequeue-side) endpoint of the gray-coded asynchronous crossing interface; it terminates the mem/widx/ridx/safe bundle that a transmitting endpoint drives from another clock domain.
- Synchronizes the incoming write index and reads slots from the transmitter's memory array.
- Presents entries on a registered ready/valid dequeue port and returns a gray-coded read index.
- Runs entirely on the dequeue clock; the transmitting endpoint is a separate block.

Parameters:
- WIDTH, 4, payload bits per entry.
- DEPTH, 8, entries in the transmitter memory; power of two, at least 2; ADDR = log2(DEPTH).
- SYNC, 3, flop stages in each crossing synchronizer; at least 2.

Ports:
- clock  in  1  dequeue-domain clock.
- reset  in  1  synchronous, active-high reset.
- io_deq_ready  in  1  consumer accepts the entry this cycle.
- io_deq_valid  out  1  output register holds a valid entry.
- io_deq_bits  out  WIDTH  output payload.
- io_async_mem  in  WIDTH*DEPTH  transmitter slots, flattened; slot k is bits [k*WIDTH +: WIDTH].
- io_async_widx  in  ADDR+1  gray-coded write index, asynchronous to clock.
- io_async_ridx  out  ADDR+1  gray-coded read index, registered.
- io_async_safe_widx_valid  in  1  transmitter index valid, asynchronous.
- io_async_safe_source_reset_n  in  1  transmitter out of reset, asynchronous.
- io_async_safe_ridx_valid  out  1  this endpoint's read index is valid.
- io_async_safe_sink_reset_n  out  1  this endpoint is out of reset.

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-high.
- Reset values: every register is cleared, including synchronizer stages. Outputs io_deq_valid, io_deq_bits, io_async_ridx, io_async_safe_ridx_valid and io_async_safe_sink_reset_n are all 0.
- io_async_safe_sink_reset_n: a register set to 1 on the first cycle after reset deasserts.
- SYNC-stage synchronizers:
  - widx_s from io_async_widx.
  - src_ok_s from io_async_safe_source_reset_n.
  - wv_s from io_async_safe_widx_valid.
- tx_ready = src_ok_s & wv_s.
- Read pointer:
  - rbin is an ADDR+1-bit binary counter; rgray is a register always loaded with gray(rbin_next), where gray(x) = x ^ (x>>1).
  - io_async_ridx = rgray.
  - rbin wraps modulo 2*DEPTH; no special case at the wrap.
- avail = tx_ready & (rgray != widx_s). Empty means rgray == widx_s. Full detection belongs to the transmitter; this block only advances ridx.
- load = avail & (!io_deq_valid | io_deq_ready). On load:
  - io_deq_bits <= slot rbin[ADDR-1:0];
  - io_deq_valid <= 1;
  - rbin <= rbin+1.
- If there is no load and io_deq_ready is high, io_deq_valid <= 0.
- io_deq_bits holds its value while io_deq_valid=1 and io_deq_ready=0.
- Simultaneous pop and load: back-to-back throughput of 1 entry per cycle while avail holds.
- Latency: a widx change at the input pin shows as io_deq_valid=1 SYNC+1 cycles later (SYNC to synchronize, 1 for the output register).
- io_async_safe_ridx_valid <= src_ok_s, registered.
- Transmitter reset mid-stream (src_ok_s falls):
  - next cycle, rbin, rgray and io_deq_valid are cleared and io_async_safe_ridx_valid goes to 0;
  - any entry held in the output register is dropped;
  - operation resumes from index 0 once src_ok_s and wv_s are both 1 again.
- Local reset mid-operation: all state is cleared in the same cycle reset is sampled high; io_async_safe_sink_reset_n drops to 0.
- io_deq_bits is don't-care while io_deq_valid=0, but it must never change on a cycle where io_deq_valid=1 and io_deq_ready=0.

Test Plan:
- Idle start: release reset, drive src_reset_n=1 and widx_valid=1, set mem slot0=0xA, widx gray 1 (0b0001) and hold ready=0 → io_deq_valid rises exactly SYNC+1 cycles later with bits=0xA, holds while ready=0, and ridx=0b0001.
- Burst with wrap: write 20 sequential values into slots with gray widx advancing, ready=1 → 20 beats in order with no gaps once synchronized; ridx passes 0b1000 (rbin=15) and wraps to 0b0000 after rbin=15+1.
- Backpressure: toggle ready randomly with 8 entries pending → no loss and no duplication, bits stable under stall, total 8 fires.
- Empty boundary: widx equals rgray → io_deq_valid falls after the last pop and ridx stops changing.
- Transmitter reset: drop io_async_safe_source_reset_n with 3 entries pending → within SYNC+1 cycles valid=0, ridx=0 and ridx_valid=0; after release with widx=1, slot0 is delivered.
- Local reset mid-burst: assert reset for 1 cycle → every output is 0 the next cycle; io_async_safe_sink_reset_n returns to 1 one cycle after reset deasserts.
